// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the I-cache/D-cache memory port arbiter.
package mem_arbiter_pkg;
    localparam int unsigned MEM_ADDR_BITS = 28;
    localparam int unsigned MEM_DATA_BITS = 128;
    localparam int unsigned MEM_MASK_BITS = MEM_DATA_BITS / 8;
    localparam int unsigned READ_BEATS    = 4;
    localparam logic [1:0]  LastBeat      = 2'(READ_BEATS - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWrWait = 2'd1,
        StRdResp = 2'd2
    } state_e;

    typedef enum logic {
        ClIc = 1'b0,
        ClDc = 1'b1
    } client_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Request/write-data/read-response bundle shared by the cache clients and the memory port.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                     req_valid;
    logic                     req_ready;
    logic [MEM_ADDR_BITS-1:0] req_addr;
    logic                     req_rw;
    logic                     data_valid;
    logic                     data_ready;
    logic [MEM_DATA_BITS-1:0] data_bits;
    logic [MEM_MASK_BITS-1:0] data_mask;
    logic                     resp_valid;
    logic [MEM_DATA_BITS-1:0] resp_data;

    // master issues requests (cache side, or the arbiter toward memory)
    modport master (
        output req_valid, req_addr, req_rw, data_valid, data_bits, data_mask,
        input  req_ready, data_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_rw, data_valid, data_bits, data_mask,
        output req_ready, data_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational grant picker; MEM_ARB_RR_EN selects round-robin ties, else D-cache wins ties.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic    i_ic_valid,
    input  logic    i_dc_valid,
    input  client_e i_rr_ptr,
    output client_e o_grant
);
`ifndef MEM_ARB_RR_EN
    logic w_unused_ptr;
    assign w_unused_ptr = i_rr_ptr;
`endif

    always_comb begin
        o_grant = ClDc;
        if (i_ic_valid && i_dc_valid) begin
`ifdef MEM_ARB_RR_EN
            o_grant = i_rr_ptr;
`else
            o_grant = ClDc;
`endif
        end else if (i_ic_valid) begin
            o_grant = ClIc;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache: one transaction at a time, 4-beat reads.
// Optional MEM_ARB_RR_EN: round-robin tie breaking instead of fixed D-cache priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  io_ic,
    mem_arbiter_if.slave  io_dc,
    mem_arbiter_if.master io_mem
);
    state_e     r_state;
    client_e    r_owner;
    logic       r_req_done;
    logic       r_data_done;
    logic [1:0] r_beat_cnt;
    client_e    w_rr_ptr;
    client_e    w_pick;
    client_e    w_sel;

`ifdef MEM_ARB_RR_EN
    client_e r_rr_ptr;
    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = ClIc;
`endif

    mem_arbiter_pick u_pick (
        .i_ic_valid (io_ic.req_valid),
        .i_dc_valid (io_dc.req_valid),
        .i_rr_ptr   (w_rr_ptr),
        .o_grant    (w_pick)
    );

    // Outside IDLE only the latched owner is forwarded.
    assign w_sel = (r_state == StIdle) ? w_pick : r_owner;

    logic w_sel_req_valid, w_sel_rw, w_sel_data_valid;
    assign w_sel_req_valid  = (w_sel == ClDc) ? io_dc.req_valid  : io_ic.req_valid;
    assign w_sel_rw         = (w_sel == ClDc) ? io_dc.req_rw     : io_ic.req_rw;
    assign w_sel_data_valid = (w_sel == ClDc) ? io_dc.data_valid : io_ic.data_valid;

    assign io_mem.req_addr  = (w_sel == ClDc) ? io_dc.req_addr  : io_ic.req_addr;
    assign io_mem.req_rw    = w_sel_rw;
    assign io_mem.data_bits = (w_sel == ClDc) ? io_dc.data_bits : io_ic.data_bits;
    assign io_mem.data_mask = (w_sel == ClDc) ? io_dc.data_mask : io_ic.data_mask;

    logic w_mem_req_valid, w_mem_data_valid;
    always_comb begin
        w_mem_req_valid  = 1'b0;
        w_mem_data_valid = 1'b0;
        if (!reset) begin
            unique case (r_state)
                StIdle: begin
                    w_mem_req_valid  = w_sel_req_valid;
                    w_mem_data_valid = w_sel_req_valid & w_sel_rw & w_sel_data_valid;
                end
                StWrWait: begin
                    w_mem_req_valid  = w_sel_req_valid & ~r_req_done;
                    w_mem_data_valid = w_sel_data_valid & ~r_data_done;
                end
                default: ;
            endcase
        end
    end

    assign io_mem.req_valid  = w_mem_req_valid;
    assign io_mem.data_valid = w_mem_data_valid;

    logic w_req_hs, w_data_hs, w_resp_fire;
    assign w_req_hs    = w_mem_req_valid & io_mem.req_ready;
    assign w_data_hs   = w_mem_data_valid & io_mem.data_ready;
    assign w_resp_fire = ~reset & (r_state == StRdResp) & io_mem.resp_valid;

    assign io_ic.req_ready  = w_req_hs & (w_sel == ClIc);
    assign io_dc.req_ready  = w_req_hs & (w_sel == ClDc);
    assign io_ic.data_ready = w_data_hs & (w_sel == ClIc);
    assign io_dc.data_ready = w_data_hs & (w_sel == ClDc);
    assign io_ic.resp_valid = w_resp_fire & (r_owner == ClIc);
    assign io_dc.resp_valid = w_resp_fire & (r_owner == ClDc);
    assign io_ic.resp_data  = io_mem.resp_data;
    assign io_dc.resp_data  = io_mem.resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_owner     <= ClIc;
            r_req_done  <= 1'b0;
            r_data_done <= 1'b0;
            r_beat_cnt  <= 2'd0;
`ifdef MEM_ARB_RR_EN
            r_rr_ptr    <= ClIc;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_req_hs && !w_sel_rw) begin
                        r_owner    <= w_sel;
                        r_beat_cnt <= 2'd0;
                        r_state    <= StRdResp;
                    end else if (w_req_hs && w_data_hs) begin
`ifdef MEM_ARB_RR_EN
                        r_rr_ptr <= client_e'(~w_sel);
`endif
                    end else if (w_req_hs || w_data_hs) begin
                        r_owner     <= w_sel;
                        r_req_done  <= w_req_hs;
                        r_data_done <= w_data_hs;
                        r_state     <= StWrWait;
                    end
                end
                StWrWait: begin
                    if ((r_req_done || w_req_hs) && (r_data_done || w_data_hs)) begin
                        r_req_done  <= 1'b0;
                        r_data_done <= 1'b0;
                        r_state     <= StIdle;
`ifdef MEM_ARB_RR_EN
                        r_rr_ptr    <= client_e'(~w_sel);
`endif
                    end else begin
                        r_req_done  <= r_req_done | w_req_hs;
                        r_data_done <= r_data_done | w_data_hs;
                    end
                end
                StRdResp: begin
                    if (io_mem.resp_valid) begin
                        r_beat_cnt <= r_beat_cnt + 2'd1;
                        if (r_beat_cnt == LastBeat) begin
                            r_state <= StIdle;
`ifdef MEM_ARB_RR_EN
                            r_rr_ptr <= client_e'(~w_sel);
`endif
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences, random vs model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if ic_if ();
    mem_arbiter_if dc_if ();
    mem_arbiter_if mem_if ();

    mem_arbiter u_dut (
        .clk    (clk),
        .reset  (reset),
        .io_ic  (ic_if),
        .io_dc  (dc_if),
        .io_mem (mem_if)
    );

    localparam logic [27:0] IcAddr = 28'h0000010;
    localparam logic [27:0] DcAddr = 28'h00000A3;

    int n_checks = 0;
    int n_errors = 0;

    // Input vector {ic v,rw,dv | dc v,rw,dv | mem req_rdy,data_rdy,resp_v}
    // Output vector {ic rr,dr,rv | dc rr,dr,rv | mem req_v,data_v}
    typedef struct packed {
        logic [8:0]  in;
        logic [7:0]  exp;
        logic        chk_addr;
        logic [27:0] addr;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [7:0] obs();
        return {ic_if.req_ready, ic_if.data_ready, ic_if.resp_valid,
                dc_if.req_ready, dc_if.data_ready, dc_if.resp_valid,
                mem_if.req_valid, mem_if.data_valid};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [159:0] act,
                              input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [8:0] v);
        ic_if.req_valid   = v[8];
        ic_if.req_rw      = v[7];
        ic_if.data_valid  = v[6];
        dc_if.req_valid   = v[5];
        dc_if.req_rw      = v[4];
        dc_if.data_valid  = v[3];
        mem_if.req_ready  = v[2];
        mem_if.data_ready = v[1];
        mem_if.resp_valid = v[0];
    endtask

    task automatic cyc(input string name, input logic [8:0] v, input logic [7:0] e);
        @(negedge clk);
        set_in(v);
        #1;
        check8(name, obs(), e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_in(9'b000_000_000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check8("reset outputs", obs(), 8'b000_000_00);
    endtask

    // Random-phase state: model of the arbiter at transaction level, plus client agents.
    int          m_kind;  // 0 free, 1 read refill outstanding, 2 write partially done
    int          m_own, m_left, m_ptr;
    bit          m_need_req, m_need_data;
    bit          c_pend[2], c_rw[2], c_nreq[2], c_ndat[2];
    logic [27:0]  c_addr[2];
    logic [127:0] c_data[2];
    logic [15:0]  c_mask[2];
    bit          v[2], dv[2], e_rr[2], e_dr[2], e_rv[2], e_mv, e_mdv, mrr, mdr, mrv;
    logic [127:0] mdata;
    int          w;

    initial begin
        reset = 1'b1;
        set_in(9'b000_000_000);
        ic_if.req_addr   = IcAddr;
        dc_if.req_addr   = DcAddr;
        ic_if.data_bits  = {4{32'h1C1C_0000}};
        dc_if.data_bits  = {4{32'hDCDC_0000}};
        ic_if.data_mask  = 16'hFFFF;
        dc_if.data_mask  = 16'h00FF;
        mem_if.resp_data = '0;

        vecs[0]  = '{9'b000_000_000, 8'b000_000_00, 1'b0, 28'h0};
        vecs[1]  = '{9'b100_000_000, 8'b000_000_10, 1'b1, IcAddr};
        vecs[2]  = '{9'b000_100_000, 8'b000_000_10, 1'b1, DcAddr};
`ifdef MEM_ARB_RR_EN
        vecs[3]  = '{9'b100_100_000, 8'b000_000_10, 1'b1, IcAddr};
`else
        vecs[3]  = '{9'b100_100_000, 8'b000_000_10, 1'b1, DcAddr};
`endif
        vecs[4]  = '{9'b000_111_000, 8'b000_000_11, 1'b1, DcAddr};
        vecs[5]  = '{9'b110_000_000, 8'b000_000_10, 1'b1, IcAddr};
        vecs[6]  = '{9'b000_000_001, 8'b000_000_00, 1'b0, 28'h0};
        vecs[7]  = '{9'b100_000_001, 8'b000_000_10, 1'b1, IcAddr};
        vecs[8]  = '{9'b000_111_110, 8'b000_110_11, 1'b1, DcAddr};
        vecs[9]  = '{9'b100_000_000, 8'b000_000_10, 1'b1, IcAddr};
        vecs[10] = '{9'b000_000_000, 8'b000_000_00, 1'b0, 28'h0};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
            if (vecs[i].chk_addr)
                check_wide($sformatf("vec%0d addr", i), 160'(mem_if.req_addr), 160'(vecs[i].addr));
        end

        // IC read refill with gaps between beats
        cyc("t2 grant", 9'b100_000_100, 8'b100_000_10);
        begin
            bit pat[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            int k = 0;
            for (int i = 0; i < 7; i++) begin
                mem_if.resp_data = {4{32'hBEA7_0000 + 32'(k)}};
                cyc($sformatf("t2 beat%0d", i), {6'b000_000, 2'b00, pat[i]},
                    pat[i] ? 8'b001_000_00 : 8'b000_000_00);
                if (pat[i]) begin
                    check_wide("t2 data", 160'(ic_if.resp_data), 160'({4{32'hBEA7_0000 + 32'(k)}}));
                    k++;
                end
            end
        end
        cyc("t2 idle after", 9'b000_100_000, 8'b000_000_10);
        check_wide("t2 idle addr", 160'(mem_if.req_addr), 160'(DcAddr));

        // Simultaneous reads: D-cache first, I-cache right after its last beat
        cyc("t3 tie", 9'b100_100_100, 8'b000_100_10);
        for (int i = 0; i < 4; i++)
            cyc("t3 dc beat", 9'b100_000_001, 8'b000_001_00);
        cyc("t3 ic grant", 9'b100_000_100, 8'b100_000_10);
        check_wide("t3 ic addr", 160'(mem_if.req_addr), 160'(IcAddr));
        for (int i = 0; i < 4; i++)
            cyc("t3 ic beat", 9'b000_000_001, 8'b001_000_00);

        // D-cache write: request accepted cycle 0, data accepted cycle 3
        cyc("t4 c0", 9'b100_111_100, 8'b000_100_11);
        cyc("t4 c1", 9'b100_011_100, 8'b000_000_01);
        cyc("t4 c2", 9'b100_011_100, 8'b000_000_01);
        check_wide("t4 data", {mem_if.data_bits, 16'h0, mem_if.data_mask},
                   {dc_if.data_bits, 16'h0, 16'h00FF});
        cyc("t4 c3", 9'b100_011_110, 8'b000_010_01);
        cyc("t4 c4", 9'b100_000_100, 8'b100_000_10);
        for (int i = 0; i < 4; i++)
            cyc("t4 ic beat", 9'b000_000_001, 8'b001_000_00);

        // Reset in the middle of a refill
        cyc("t1 grant", 9'b100_000_100, 8'b100_000_10);
        cyc("t1 beat1", 9'b000_000_001, 8'b001_000_00);
        @(negedge clk);
        reset = 1'b1;
        set_in(9'b000_000_000);
        @(negedge clk);
        reset = 1'b0;
        cyc("t1 drop2", 9'b000_000_001, 8'b000_000_00);
        cyc("t1 drop3", 9'b000_000_001, 8'b000_000_00);
        cyc("t1 regrant", 9'b100_000_100, 8'b100_000_10);
        for (int i = 0; i < 4; i++)
            cyc("t1 beat", 9'b000_000_001, 8'b001_000_00);

        // Random traffic against the transaction-level model
        do_reset();
        m_kind = 0; m_ptr = 0; m_own = 0; m_left = 0; m_need_req = 0; m_need_data = 0;
        for (int c = 0; c < 2; c++) begin
            c_pend[c] = 0; c_nreq[c] = 0; c_ndat[c] = 0; c_rw[c] = 0;
            c_addr[c] = '0; c_data[c] = '0; c_mask[c] = '0;
        end
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (!c_pend[c] && $urandom_range(0, 2) == 0) begin
                    c_pend[c] = 1;
                    c_rw[c]   = 1'($urandom_range(0, 1));
                    c_nreq[c] = 1;
                    c_ndat[c] = c_rw[c];
                    c_addr[c] = 28'($urandom);
                    c_data[c] = {$urandom, $urandom, $urandom, $urandom};
                    c_mask[c] = 16'($urandom);
                end
                v[c]  = c_pend[c] && c_nreq[c];
                dv[c] = c_pend[c] && c_ndat[c];
            end
            ic_if.req_valid  = v[0];  ic_if.req_rw = c_rw[0];  ic_if.data_valid = dv[0];
            ic_if.req_addr   = c_addr[0]; ic_if.data_bits = c_data[0]; ic_if.data_mask = c_mask[0];
            dc_if.req_valid  = v[1];  dc_if.req_rw = c_rw[1];  dc_if.data_valid = dv[1];
            dc_if.req_addr   = c_addr[1]; dc_if.data_bits = c_data[1]; dc_if.data_mask = c_mask[1];
            mrr = 1'($urandom_range(0, 1));
            mdr = 1'($urandom_range(0, 1));
            mrv = 1'($urandom_range(0, 1));
            mdata = {$urandom, $urandom, $urandom, $urandom};
            mem_if.req_ready = mrr; mem_if.data_ready = mdr;
            mem_if.resp_valid = mrv; mem_if.resp_data = mdata;
            #1;

            e_rr = '{0, 0}; e_dr = '{0, 0}; e_rv = '{0, 0}; e_mv = 0; e_mdv = 0; w = -1;
            if (m_kind == 1) begin
                if (mrv) begin
                    e_rv[m_own] = 1;
                    m_left--;
                    if (m_left == 0) begin m_kind = 0; m_ptr = 1 - m_own; end
                end
            end else if (m_kind == 2) begin
                w = m_own;
                e_mv  = v[w] && m_need_req;
                e_mdv = dv[w] && m_need_data;
                if (e_mv && mrr)  begin e_rr[w] = 1; m_need_req = 0; end
                if (e_mdv && mdr) begin e_dr[w] = 1; m_need_data = 0; end
                if (!m_need_req && !m_need_data) begin m_kind = 0; m_ptr = 1 - w; end
            end else begin
`ifdef MEM_ARB_RR_EN
                if (v[0] && v[1]) w = m_ptr;
`else
                if (v[0] && v[1]) w = 1;
`endif
                else if (v[1]) w = 1;
                else if (v[0]) w = 0;
                if (w >= 0) begin
                    e_mv  = 1;
                    e_mdv = c_rw[w] && dv[w];
                    e_rr[w] = mrr;
                    e_dr[w] = e_mdv && mdr;
                    if (!c_rw[w]) begin
                        if (mrr) begin m_kind = 1; m_own = w; m_left = READ_BEATS; end
                    end else if (e_rr[w] && e_dr[w]) begin
                        m_ptr = 1 - w;
                    end else if (e_rr[w] || e_dr[w]) begin
                        m_kind = 2; m_own = w; m_need_req = !e_rr[w]; m_need_data = !e_dr[w];
                    end
                end
            end

            check8($sformatf("rand%0d ctl", n), obs(),
                   {e_rr[0], e_dr[0], e_rv[0], e_rr[1], e_dr[1], e_rv[1], e_mv, e_mdv});
            if (e_mv)
                check_wide($sformatf("rand%0d req", n), 160'({mem_if.req_addr, mem_if.req_rw}),
                           160'({c_addr[w], c_rw[w]}));
            if (e_mdv)
                check_wide($sformatf("rand%0d wdata", n), {mem_if.data_bits, 16'h0, mem_if.data_mask},
                           {c_data[w], 16'h0, c_mask[w]});
            if (e_rv[0])
                check_wide($sformatf("rand%0d ic rdata", n), 160'(ic_if.resp_data), 160'(mdata));
            if (e_rv[1])
                check_wide($sformatf("rand%0d dc rdata", n), 160'(dc_if.resp_data), 160'(mdata));

            for (int c = 0; c < 2; c++) begin
                if (e_rr[c]) c_nreq[c] = 0;
                if (e_dr[c]) c_ndat[c] = 0;
                if (c_pend[c] && !c_nreq[c] && !c_ndat[c]) c_pend[c] = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
